// File: rtl/serial_alu_pkg.sv
// ============================================================================
//  Module      : serial_alu_pkg
//  Description : Shared op codes, FSM state encoding and op-decode helpers
//                for the bit-serial ALU sequencer and its 1-bit slice.
//                Honours SERIAL_ALU_SLT_EN (control 1 becomes SLT).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_alu_pkg;

    localparam logic [2:0] ALU_SLT = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;
    localparam logic [2:0] ALU_NOR = 3'd6;
    localparam logic [2:0] ALU_XOR = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ops that run as A + ~B + 1 through the slice.
    function automatic logic op_is_sub(input logic [2:0] op);
`ifdef SERIAL_ALU_SLT_EN
        return (op == ALU_SUB) || (op == ALU_SLT);
`else
        return (op == ALU_SUB);
`endif
    endfunction

    // Ops that report carryout and overflow.
    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

    // The slice only knows how to add; subtraction is an add of the inverted operand.
    function automatic logic [2:0] slice_op(input logic [2:0] op);
        return op_is_sub(op) ? ALU_ADD : op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu1.sv
// ============================================================================
//  Module      : alu1
//  Description : Combinational 1-bit ALU slice: full-adder plus bitwise ops.
//                Reserved op codes produce out=0, carryout=0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu1
    import serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       carryin,
    input  logic [2:0] control,
    output logic       out,
    output logic       carryout
);

    always_comb begin
        out      = 1'b0;
        carryout = 1'b0;
        case (control)
            ALU_ADD: begin
                out      = a ^ b ^ carryin;
                carryout = (a & b) | (carryin & (a ^ b));
            end
            ALU_AND: out = a & b;
            ALU_OR:  out = a | b;
            ALU_NOR: out = ~(a | b);
            ALU_XOR: out = a ^ b;
            default: begin
                out      = 1'b0;
                carryout = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_serial_seq.sv
// ============================================================================
//  Module      : alu_serial_seq
//  Description : Bit-serial WIDTH-bit ALU sequencer around one alu1 slice,
//                LSB first, with valid/ready handshakes on operands and result.
//                Optional feature macro: SERIAL_ALU_SLT_EN (control 1 = SLT).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_serial_seq
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [2:0]         op_q, op_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carryout_q, carryout_d;
    logic               overflow_q, overflow_d;
    logic               zero_q, zero_d;
    logic               negative_q, negative_d;

    logic               slice_a;
    logic               slice_b;
    logic [2:0]         slice_ctrl;
    logic               slice_out;
    logic               slice_co;

    logic [WIDTH-1:0]   final_res;
    logic               final_co;
    logic               final_ov;
    logic               msb_ov;

    assign slice_a    = a_sh_q[0];
    assign slice_b    = b_sh_q[0] ^ op_is_sub(op_q);
    assign slice_ctrl = slice_op(op_q);

    alu1 u_alu1 (
        .a        (slice_a),
        .b        (slice_b),
        .carryin  (carry_q),
        .control  (slice_ctrl),
        .out      (slice_out),
        .carryout (slice_co)
    );

    // Result bits enter at the top of the A register as A drains out the bottom,
    // so after WIDTH shifts the A register holds the finished word.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        op_d       = op_q;
        carry_d    = carry_q;
        result_d   = result_q;
        carryout_d = carryout_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        negative_d = negative_q;

        final_res  = {slice_out, a_sh_q[WIDTH-1:1]};
        msb_ov     = carry_q ^ slice_co;
        final_co   = op_is_arith(op_q) & slice_co;
        final_ov   = op_is_arith(op_q) & msb_ov;
`ifdef SERIAL_ALU_SLT_EN
        if (op_q == ALU_SLT) begin
            final_res = {{(WIDTH-1){1'b0}}, slice_out ^ msb_ov};
            final_co  = 1'b0;
            final_ov  = 1'b0;
        end
`endif

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    op_d    = control;
                    cnt_d   = '0;
                    carry_d = op_is_sub(control);
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = final_res;
                b_sh_d  = {b_sh_q[0], b_sh_q[WIDTH-1:1]};
                carry_d = slice_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    cnt_d      = '0;
                    result_d   = final_res;
                    carryout_d = final_co;
                    overflow_d = final_ov;
                    zero_d     = (final_res == '0);
                    negative_d = final_res[WIDTH-1];
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            op_q       <= '0;
            carry_q    <= 1'b0;
            result_q   <= '0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            op_q       <= op_d;
            carry_q    <= carry_d;
            result_q   <= result_d;
            carryout_q <= carryout_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carryout  = carryout_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign negative  = negative_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_serial_seq.sv
// ============================================================================
//  Module      : tb_alu_serial_seq
//  Description : Self-checking bench for alu_serial_seq (WIDTH=8 and WIDTH=32).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_serial_seq;
    import serial_alu_pkg::*;

    localparam int W  = 8;
    localparam int WW = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic           in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [W-1:0]   a = '0, b = '0, result;
    logic [2:0]     control = 3'd0;
    logic           carryout, overflow, zero, negative;

    logic           w_in_valid = 1'b0, w_in_ready, w_out_valid, w_out_ready = 1'b0;
    logic [WW-1:0]  w_a = '0, w_b = '0, w_result;
    logic [2:0]     w_control = 3'd0;
    logic           w_carryout, w_overflow, w_zero, w_negative;

    alu_serial_seq #(.WIDTH(W)) u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .control(control), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carryout(carryout), .overflow(overflow), .zero(zero),
        .negative(negative)
    );

    alu_serial_seq #(.WIDTH(WW)) u_dut32 (
        .clock(clock), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .control(w_control), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .result(w_result), .carryout(w_carryout),
        .overflow(w_overflow), .zero(w_zero), .negative(w_negative)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        logic         z;
        logic         n;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t       e;
        logic [W:0] s;
        e = '0;
        s = '0;
        case (op)
            3'd2: begin
                s    = {1'b0, x} + {1'b0, y};
                e.res = s[W-1:0];
                e.co = s[W];
                e.ov = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
            end
            3'd3: begin
                s    = {1'b0, x} + {1'b0, ~y} + 1;
                e.res = s[W-1:0];
                e.co = s[W];
                e.ov = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
            end
            3'd4: e.res = x & y;
            3'd5: e.res = x | y;
            3'd6: e.res = ~(x | y);
            3'd7: e.res = x ^ y;
`ifdef SERIAL_ALU_SLT_EN
            3'd1: e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
`endif
            default: e.res = '0;
        endcase
        e.z = (e.res == '0);
        e.n = e.res[W-1];
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int t_acc);
        int k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: in_ready=%b required 1 after %0d cycles", in_ready, k);
        end
        in_valid = 1'b1;
        a        = x;
        b        = y;
        control  = op;
        sb.push_back(model(op, x, y));
        @(posedge clock);
        @(negedge clock);
        t_acc    = cyc;
        in_valid = 1'b0;
    endtask

    // Waits for the result, checks latency/values, holds for 'hold' cycles, then handshakes.
    task automatic finish(input string tag, input int hold);
        int   lat = 0;
        exp_t e;
        logic [W+3:0] snap;
        while (!out_valid && lat < W + 20) begin
            @(posedge clock);
            @(negedge clock);
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1 || lat != W) begin
            errors++;
            $display("FAIL %s_latency: out_valid=%b after %0d edges, required 1 after %0d", tag, out_valid, lat, W);
        end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++;
        if (result !== e.res) begin
            errors++;
            $display("FAIL %s_result: got %h required %h", tag, result, e.res);
        end
        checks++;
        if ({carryout, overflow, zero, negative} !== {e.co, e.ov, e.z, e.n}) begin
            errors++;
            $display("FAIL %s_flags: got c/v/z/n=%b required %b", tag,
                     {carryout, overflow, zero, negative}, {e.co, e.ov, e.z, e.n});
        end
        snap = {result, carryout, overflow, zero, negative};
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a        = W'($urandom);
            b        = W'($urandom);
            control  = ALU_ADD;
            @(posedge clock);
            @(negedge clock);
            checks++;
            if ({out_valid, in_ready, result, carryout, overflow, zero, negative} !== {2'b10, snap}) begin
                errors++;
                $display("FAIL %s_hold%0d: got v/r=%b%b data=%h required v/r=10 data=%h", tag, i,
                         out_valid, in_ready, {result, carryout, overflow, zero, negative}, snap);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: in_ready=%b out_valid=%b required 1 and 0", tag, in_ready, out_valid);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int hold);
        int t;
        issue(op, x, y, t);
        finish(tag, hold);
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({in_ready, out_valid, result, carryout, overflow, zero, negative} !== {2'b10, {W{1'b0}}, 4'b0}) begin
            errors++;
            $display("FAIL reset8: got r/v=%b%b res=%h flags=%b required r/v=10 res=00 flags=0000",
                     in_ready, out_valid, result, {carryout, overflow, zero, negative});
        end
        checks++;
        if ({w_in_ready, w_out_valid, w_result, w_carryout, w_overflow, w_zero, w_negative} !== {2'b10, {WW{1'b0}}, 4'b0}) begin
            errors++;
            $display("FAIL reset32: got r/v=%b%b res=%h required r/v=10 res=0", w_in_ready, w_out_valid, w_result);
        end
    endtask

    task automatic test_add();
        run_op("add_ovf", ALU_ADD, 8'h7F, 8'h01, 0);
        run_op("add_carry", ALU_ADD, 8'hC8, 8'h64, 0);
    endtask

    task automatic test_sub();
        run_op("sub_eq", ALU_SUB, 8'h05, 8'h05, 0);
        run_op("sub_borrow", ALU_SUB, 8'h00, 8'h01, 0);
        run_op("sub_ovf", ALU_SUB, 8'h80, 8'h01, 0);
    endtask

    task automatic test_logic();
        run_op("xor", ALU_XOR, 8'hA5, 8'hFF, 0);
        run_op("nor", ALU_NOR, 8'h0F, 8'hF0, 0);
        run_op("or", ALU_OR, 8'h81, 8'h18, 0);
        run_op("and", ALU_AND, 8'hF0, 8'h3C, 0);
    endtask

    task automatic test_reset_mid();
        int t;
        issue(ALU_ADD, 8'h11, 8'h22, t);
        void'(sb.pop_back());
        @(posedge clock);
        @(negedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b result=%h required 1 0 00", in_ready, out_valid, result);
        end
        run_op("add_after_reset", ALU_ADD, 8'h01, 8'h02, 0);
    endtask

    task automatic test_hold();
        run_op("hold", ALU_ADD, 8'h12, 8'h34, 5);
    endtask

    task automatic test_slt();
        run_op("slt_neg_lt", 3'd1, 8'h80, 8'h01, 0);
        run_op("slt_pos_ge", 3'd1, 8'h01, 8'h80, 0);
        run_op("reserved0", 3'd0, 8'hFF, 8'h01, 0);
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        issue(ALU_SUB, 8'h10, 8'h20, t1);
        finish("b2b_first", 0);
        issue(ALU_XOR, 8'h3C, 8'h0F, t2);
        checks++;
        if (t2 - t1 != W + 2) begin
            errors++;
            $display("FAIL b2b_period: got %0d cycles required %0d", t2 - t1, W + 2);
        end
        finish("b2b_second", 0);
    endtask

    task automatic test_wide();
        int lat = 0;
        w_in_valid = 1'b1;
        w_a        = 32'hFFFF_FFFF;
        w_b        = 32'h0000_0001;
        w_control  = ALU_ADD;
        @(posedge clock);
        @(negedge clock);
        w_in_valid = 1'b0;
        while (!w_out_valid && lat < WW + 20) begin
            @(posedge clock);
            @(negedge clock);
            lat++;
        end
        checks++;
        if (w_out_valid !== 1'b1 || lat != WW) begin
            errors++;
            $display("FAIL wide_latency: out_valid=%b after %0d edges required 1 after %0d", w_out_valid, lat, WW);
        end
        checks++;
        if (w_result !== 32'h0 || {w_carryout, w_overflow, w_zero, w_negative} !== 4'b1010) begin
            errors++;
            $display("FAIL wide_add: got %h c/v/z/n=%b required 00000000 1010", w_result,
                     {w_carryout, w_overflow, w_zero, w_negative});
        end
        w_out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        w_out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_reset_mid();
        test_hold();
        test_slt();
        test_back_to_back();
        test_wide();
        test_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
